// File: rtl/io_port_responder.sv
// CPU I/O port responder: registered OUT ports, IN read mux over synced switches,
// sticky key-press flags and a millisecond tick counter.

module io_port_responder_key_lane (
    input  logic clk,
    input  logic reset,
    input  logic key_n_raw,
    input  logic arm,
    input  logic clr,
    output logic evt
);
    logic s1, sync, prev, fall;

    assign fall = arm & prev & ~sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
            evt  <= 1'b0;
        end else begin
            s1   <= key_n_raw;
            sync <= s1;
            prev <= sync;
            // a fresh press survives a coincident clearing read
            evt  <= (evt & ~clr) | fall;
        end
    end
endmodule

module io_port_responder #(
    parameter int DATA_W   = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_out,
    input  logic              s_in,
    input  logic [1:0]        port_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] sw_raw,
    input  logic [3:0]        key_n_raw,
    output logic [DATA_W-1:0] out_p0,
    output logic [DATA_W-1:0] out_p1,
    output logic [DATA_W-1:0] out_p2,
    output logic [DATA_W-1:0] out_p3,
    output logic              tick
);
    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int STAGES = 2;

    logic [3:0][DATA_W-1:0] out_p;
    logic [DATA_W-1:0]      sw_s1, sw_sync;
    logic [STAGES:0]        vld_pipe;
    logic [3:0]             key_evt;
    logic [DIV_W-1:0]       div_cnt;
    logic [7:0]             ms_cnt;
    logic                   tick_pend, wrap, rd_key, rd_tick;

    assign rd_key  = s_in && (port_addr == 2'd1);
    assign rd_tick = s_in && (port_addr == 2'd3);
    assign wrap    = (div_cnt == DIV_W'(TICK_DIV - 1));

    assign out_p0 = out_p[0];
    assign out_p1 = out_p[1];
    assign out_p2 = out_p[2];
    assign out_p3 = out_p[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_p <= '0;
        else if (s_out) out_p[port_addr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1   <= '0;
            sw_sync <= '0;
        end else begin
            sw_s1   <= sw_raw;
            sw_sync <= sw_s1;
        end
    end

    // Key events stay disarmed until the key synchronisers have refilled after
    // reset, so a key held through reset release is not seen as a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_pipe <= '0;
        else vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end

    for (genvar i = 0; i < 4; i++) begin : g_key
        io_port_responder_key_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .key_n_raw(key_n_raw[i]),
            .arm      (vld_pipe[STAGES]),
            .clr      (rd_key),
            .evt      (key_evt[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            ms_cnt    <= '0;
            tick      <= 1'b0;
            tick_pend <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
            tick    <= wrap;
            if (wrap) ms_cnt <= ms_cnt + 8'd1;
            if (wrap) tick_pend <= 1'b1;
            else if (rd_tick) tick_pend <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (s_in) begin
            case (port_addr)
                2'd0: rdata = sw_sync;
                2'd1: rdata = DATA_W'(key_evt);
                2'd2: rdata = DATA_W'(ms_cnt);
                2'd3: rdata = {tick_pend, {(DATA_W-1){1'b0}}};
                default: rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: write table, hand sequences for keys/ticks/reset,
// and a randomized run against a pin-history reference model.

module tb_io_port_responder;
    localparam int DW = 8;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_out = 1'b0, s_in = 1'b0;
    logic [1:0]    port_addr = 2'd0;
    logic [DW-1:0] wdata = '0, sw_raw = '0;
    logic [3:0]    key_n_raw = 4'hF;
    logic [DW-1:0] rdata, out_p0, out_p1, out_p2, out_p3;
    logic          tick;

    io_port_responder #(.DATA_W(DW), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .s_out(s_out), .s_in(s_in),
        .port_addr(port_addr), .wdata(wdata), .rdata(rdata),
        .sw_raw(sw_raw), .key_n_raw(key_n_raw),
        .out_p0(out_p0), .out_p1(out_p1), .out_p2(out_p2), .out_p3(out_p3),
        .tick(tick)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // look at rdata for an address without letting the strobe reach an edge
    task automatic peek(input logic [1:0] a, output logic [DW-1:0] v);
        logic       si;
        logic [1:0] pa;
        si = s_in; pa = port_addr;
        port_addr = a; s_in = 1'b1;
        #1 v = rdata;
        s_in = si; port_addr = pa;
    endtask

    function automatic logic [31:0] outs();
        return {out_p3, out_p2, out_p1, out_p0};
    endfunction

    // reference model: pin sample histories plus edge count since reset
    int            e;
    logic [3:0]    kh[$];
    logic [DW-1:0] sh[$];
    logic [DW-1:0] mo[4];
    logic [3:0]    mevt;
    logic          mpend, mtick;

    task automatic model_reset();
        e = 0;
        kh = '{4'hF, 4'hF, 4'hF, 4'hF};
        sh = '{8'h00, 8'h00};
        for (int i = 0; i < 4; i++) mo[i] = '0;
        mevt = '0; mpend = 1'b0; mtick = 1'b0;
    endtask

    function automatic logic [DW-1:0] model_rdata();
        if (!s_in) return '0;
        case (port_addr)
            2'd0: return sh[1];
            2'd1: return {4'h0, mevt};
            2'd2: return DW'((e / TD) % 256);
            default: return {mpend, 7'h00};
        endcase
    endfunction

    task automatic model_edge();
        logic [3:0] fell;
        e++;
        kh.push_front(key_n_raw);
        sh.push_front(sw_raw);
        if (kh.size() > 6) void'(kh.pop_back());
        if (sh.size() > 6) void'(sh.pop_back());
        // a pin that fell shows as an event 3 edges later, not within 3 edges of reset
        fell = (e >= 4) ? (kh[3] & ~kh[2]) : 4'h0;
        mevt = ((s_in && port_addr == 2'd1) ? 4'h0 : mevt) | fell;
        mtick = (e % TD == 0);
        if (mtick) mpend = 1'b1;
        else if (s_in && port_addr == 2'd3) mpend = 1'b0;
        if (s_out) mo[port_addr] = wdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] exp;
    } wr_vec_t;

    wr_vec_t tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        int ticks;

        tbl[0] = '{2'd2, 8'hA5, 32'h00A5_0000};
        tbl[1] = '{2'd0, 8'h11, 32'h00A5_0011};
        tbl[2] = '{2'd3, 8'hFF, 32'hFFA5_0011};
        tbl[3] = '{2'd2, 8'h3C, 32'hFF3C_0011};
        tbl[4] = '{2'd1, 8'h42, 32'hFF3C_4211};
        tbl[5] = '{2'd0, 8'h00, 32'hFF3C_4200};

        // reset state
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_outs", outs(), 32'h0);
        chk("rst_tick", {31'h0, tick}, 32'h0);
        chk("rst_rdata_idle", {24'h0, rdata}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            peek(2'(a), v);
            chk($sformatf("rst_rdata_a%0d", a), {24'h0, v}, 32'h0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) step();

        // OUT writes from the table
        for (int i = 0; i < 6; i++) begin
            port_addr = tbl[i].addr; wdata = tbl[i].wdata; s_out = 1'b1;
            step();
            s_out = 1'b0; wdata = 8'hEE;
            chk($sformatf("wr%0d_outs", i), outs(), tbl[i].exp);
            step();
            chk($sformatf("wr%0d_hold", i), outs(), tbl[i].exp);
        end

        // switch synchroniser latency
        sw_raw = 8'h5A;
        peek(2'd0, v); chk("sw_lag0", {24'h0, v}, 32'h00);
        step();
        peek(2'd0, v); chk("sw_lag1", {24'h0, v}, 32'h00);
        step();
        peek(2'd0, v); chk("sw_lag2", {24'h0, v}, 32'h5A);
        port_addr = 2'd0; s_in = 1'b0; #1;
        chk("sw_idle_zero", {24'h0, rdata}, 32'h00);

        // key press, read-clear, and press coincident with clearing read
        key_n_raw = 4'b1101;
        step(); step();
        peek(2'd1, v); chk("key_lat2", {24'h0, v}, 32'h00);
        step();
        peek(2'd1, v); chk("key_lat3", {24'h0, v}, 32'h02);
        port_addr = 2'd1; s_in = 1'b1; #1;
        chk("key_read1", {24'h0, rdata}, 32'h02);
        step();
        chk("key_read2", {24'h0, rdata}, 32'h00);
        step();
        s_in = 1'b0;
        key_n_raw = 4'b1111;
        repeat (4) step();
        peek(2'd1, v); chk("key_release", {24'h0, v}, 32'h00);
        key_n_raw = 4'b1110;
        repeat (3) step();
        peek(2'd1, v); chk("key0_evt", {24'h0, v}, 32'h01);
        key_n_raw = 4'b1100;
        step(); step();
        port_addr = 2'd1; s_in = 1'b1; #1;
        chk("key_coinc_read", {24'h0, rdata}, 32'h01);
        step();
        s_in = 1'b0;
        peek(2'd1, v); chk("key_coinc_after", {24'h0, v}, 32'h02);
        key_n_raw = 4'hF;

        // prescaler wrap of the millisecond counter
        do_reset();
        ticks = 0;
        for (int c = 0; c < 1030; c++) begin
            step();
            if (tick) ticks++;
        end
        chk("tick_count", ticks, 257);
        peek(2'd2, v); chk("ms_wrap", {24'h0, v}, 32'h01);
        peek(2'd3, v); chk("pend_set", {24'h0, v}, 32'h80);
        port_addr = 2'd3; s_in = 1'b1; #1;
        chk("pend_read", {24'h0, rdata}, 32'h80);
        step();
        chk("pend_cleared", {24'h0, rdata}, 32'h00);
        step();
        s_in = 1'b0;
        chk("tick_in_clear", {31'h0, tick}, 32'h1);
        peek(2'd3, v); chk("pend_set_wins", {24'h0, v}, 32'h80);
        repeat (3) step();
        port_addr = 2'd2; s_in = 1'b1; #1;
        chk("ms_pre_inc", {24'h0, rdata}, 32'h02);
        step();
        s_in = 1'b0;
        peek(2'd2, v); chk("ms_post_inc", {24'h0, v}, 32'h03);

        // randomized run against the reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            s_out = ($urandom % 3 == 0);
            s_in = ($urandom % 3 == 0);
            port_addr = 2'($urandom % 4);
            wdata = 8'($urandom);
            if ($urandom % 8 == 0) sw_raw = 8'($urandom);
            if ($urandom % 4 == 0) key_n_raw = key_n_raw ^ 4'(1 << ($urandom % 4));
            #1;
            chk("rnd_rdata", {24'h0, rdata}, {24'h0, model_rdata()});
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_outs", outs(), {mo[3], mo[2], mo[1], mo[0]});
            chk("rnd_tick", {31'h0, tick}, {31'h0, mtick});
        end

        // reset dropped mid-run with keys held low
        s_out = 1'b0; s_in = 1'b0; sw_raw = 8'hC3;
        key_n_raw = 4'h0;
        step(); step();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_outs", outs(), 32'h0);
        chk("mid_rst_tick", {31'h0, tick}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            peek(2'(a), v);
            chk($sformatf("mid_rst_a%0d", a), {24'h0, v}, 32'h0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) step();
        peek(2'd1, v); chk("mid_rst_no_evt", {24'h0, v}, 32'h00);
        key_n_raw = 4'hF;
        repeat (5) step();
        peek(2'd1, v); chk("mid_rst_release", {24'h0, v}, 32'h00);
        chk("mid_rst_outs_hold", outs(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
